// File: rtl/fpu_mul_round.sv
// Rounding/packing stage behind the FPU multiplier normalizer.
// Two registered stages (decide, apply) with valid/ready on both sides.
module fpu_mul_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [25:0] in_sig,
  input  logic [7:0]  in_exp,
  input  logic        in_of,
  input  logic        in_uf,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_fflags
);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [23:0] s1_sig_q, s1_sig_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic        s1_of_q, s1_of_d;
  logic        s1_uf_q, s1_uf_d;
  logic [2:0]  s1_rm_q, s1_rm_d;
  logic        s1_inc_q, s1_inc_d;
  logic        s1_nx_q, s1_nx_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_result_q, s2_result_d;
  logic [4:0]  s2_fflags_q, s2_fflags_d;
  logic        s2_uf_q, s2_uf_d;

  logic        s1_adv, s2_adv;
  logic [2:0]  rm_eff;
  logic        rnd_l, rnd_r, rnd_s, inexact, inc;
  logic [24:0] sum;
  logic [8:0]  exp9;
  logic [22:0] frac;
  logic        rnd_min, ovf, use_inf, uf;
  logic [31:0] res;
  logic [4:0]  flags;

  // in_uf only qualifies the zero/subnormal encoding; it travels with the op
  // but never changes the packed result or flags.
  logic unused_uf;
  assign unused_uf = s2_uf_q;

  // Handshake: s2 drains when empty or consumed, s1 moves when s2 moves.
  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_adv;
    in_ready = !s1_valid_q | s1_adv;
  end

  // Stage 1: decide the rounding increment from L/R/S and the mode.
  always_comb begin
    rm_eff  = (in_rm > RM_RMM) ? RM_RNE : in_rm;
    rnd_l   = in_sig[2];
    rnd_r   = in_sig[1];
    rnd_s   = in_sig[0];
    inexact = rnd_r | rnd_s;
    case (rm_eff)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = in_sign & inexact;
      RM_RUP:  inc = !in_sign & inexact;
      RM_RMM:  inc = rnd_r;
      default: inc = rnd_r & (rnd_s | rnd_l);
    endcase
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_sig_d   = s1_sig_q;
    s1_exp_d   = s1_exp_q;
    s1_of_d    = s1_of_q;
    s1_uf_d    = s1_uf_q;
    s1_rm_d    = s1_rm_q;
    s1_inc_d   = s1_inc_q;
    s1_nx_d    = s1_nx_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_valid & in_ready) begin
      s1_sign_d = in_sign;
      s1_sig_d  = in_sig[25:2];
      s1_exp_d  = in_exp;
      s1_of_d   = in_of;
      s1_uf_d   = in_uf;
      s1_rm_d   = rm_eff;
      s1_inc_d  = inc;
      s1_nx_d   = inexact;
    end
  end

  // Stage 2: apply the increment, fix up carry-out, detect overflow, pack.
  always_comb begin
    sum     = {1'b0, s1_sig_q} + {24'd0, s1_inc_q};
    rnd_min = 1'b0;
    if (sum[24]) begin
      exp9 = {1'b0, s1_exp_q} + 9'd1;
      frac = 23'd0;
    end else if ((s1_exp_q == 8'd0) && sum[23]) begin
      // subnormal rounded up into the smallest normal
      exp9    = 9'd1;
      frac    = sum[22:0];
      rnd_min = 1'b1;
    end else begin
      exp9 = {1'b0, s1_exp_q};
      frac = sum[22:0];
    end
    ovf = s1_of_q | (exp9 >= 9'd255);
    case (s1_rm_q)
      RM_RTZ:  use_inf = 1'b0;
      RM_RDN:  use_inf = s1_sign_q;
      RM_RUP:  use_inf = !s1_sign_q;
      default: use_inf = 1'b1;
    endcase
    if (ovf)
      res = use_inf ? {s1_sign_q, 8'hFF, 23'h000000} : {s1_sign_q, 8'hFE, 23'h7FFFFF};
    else
      res = {s1_sign_q, exp9[7:0], frac};
    // tininess after rounding: a subnormal that rounded to min-normal is not tiny
    uf    = (s1_exp_q == 8'd0) & s1_nx_q & !rnd_min & !ovf;
    flags = {2'b00, ovf, uf, s1_nx_q | ovf};

    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_fflags_d = s2_fflags_q;
    s2_uf_d     = s2_uf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = res;
        s2_fflags_d = flags;
        s2_uf_d     = s1_uf_q;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sig_q    <= 24'd0;
      s1_exp_q    <= 8'd0;
      s1_of_q     <= 1'b0;
      s1_uf_q     <= 1'b0;
      s1_rm_q     <= 3'd0;
      s1_inc_q    <= 1'b0;
      s1_nx_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= 32'd0;
      s2_fflags_q <= 5'd0;
      s2_uf_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_sig_q    <= s1_sig_d;
      s1_exp_q    <= s1_exp_d;
      s1_of_q     <= s1_of_d;
      s1_uf_q     <= s1_uf_d;
      s1_rm_q     <= s1_rm_d;
      s1_inc_q    <= s1_inc_d;
      s1_nx_q     <= s1_nx_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_fflags_q <= s2_fflags_d;
      s2_uf_q     <= s2_uf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_fflags = s2_fflags_q;
endmodule

// File: tb/tb_fpu_mul_round.sv
// Bench for fpu_mul_round: directed plan cases, backpressure, mid-flight
// reset, then random traffic scored against an arithmetic rounding model.
module tb_fpu_mul_round;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sign, in_of, in_uf;
  logic [25:0] in_sig;
  logic [7:0]  in_exp;
  logic [2:0]  in_rm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int total = 0;
  int bad   = 0;
  logic [36:0] q[$];
  logic [36:0] m_exp;
  logic [31:0] held;
  logic [31:0] rnd;
  int idx, lat;
  logic [25:0] bp_sig [4];

  fpu_mul_round dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_sig(in_sig), .in_exp(in_exp), .in_of(in_of),
    .in_uf(in_uf), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags)
  );

  always #5 clk = ~clk;

  // Reference: round the 24-bit significand by comparing the discarded
  // part against one half, then renormalize and pack. Returns {fflags, result}.
  function automatic logic [36:0] model(input logic s, input logic [7:0] e,
                                        input logic [25:0] sg, input logic of,
                                        input logic [2:0] rm);
    logic [24:0] mant;
    logic [8:0]  ex;
    logic        half, above, inexact, up, to_min, ovf, tiny, big_inf;
    int          mode;
    mant    = {1'b0, sg[25:2]};
    ex      = {1'b0, e};
    half    = sg[1] && !sg[0];
    above   = sg[1] && sg[0];
    inexact = sg[1] || sg[0];
    mode    = (rm > 3'd4) ? 0 : int'(rm);
    case (mode)
      0: up = above || (half && mant[0]);
      1: up = 1'b0;
      2: up = s && inexact;
      3: up = !s && inexact;
      default: up = half || above;
    endcase
    mant   = mant + (up ? 25'd1 : 25'd0);
    tiny   = (e == 8'd0);
    to_min = 1'b0;
    if (mant >= 25'h1000000) begin
      ex   = ex + 9'd1;
      mant = 25'd0;
    end else if (tiny && mant >= 25'h0800000) begin
      ex     = 9'd1;
      to_min = 1'b1;
    end
    ovf = of || (ex >= 9'd255);
    if (ovf) begin
      big_inf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
      return {5'b00101, big_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
    end
    return {2'b00, 1'b0, tiny && inexact && !to_min, inexact, s, ex[7:0], mant[22:0]};
  endfunction

  // Scoreboard: queue expectations at accept, compare in order at drain.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++; $error("FAIL spurious_out got=%h expected=none", out_result);
      end
      if (q.size() != 0) begin
        m_exp = q.pop_front();
        total += 2;
        assert (out_result === m_exp[31:0]) else begin
          bad++; $error("FAIL sb_result got=%h expected=%h", out_result, m_exp[31:0]);
        end
        assert (out_fflags === m_exp[36:32]) else begin
          bad++; $error("FAIL sb_fflags got=%h expected=%h", out_fflags, m_exp[36:32]);
        end
      end
    end
    if (in_valid && in_ready && !reset)
      q.push_back(model(in_sign, in_exp, in_sig, in_of, in_rm));
  end

  task automatic set_in(input logic s, input logic [7:0] e, input logic [25:0] sg,
                        input logic of, input logic [2:0] rm);
    in_sign = s; in_exp = e; in_sig = sg; in_of = of; in_rm = rm; in_uf = (e == 8'd0);
  endtask

  // Offer one op and return #1 after the accepting edge.
  task automatic drive(input logic s, input logic [7:0] e, input logic [25:0] sg,
                       input logic of, input logic [2:0] rm);
    logic acc;
    set_in(s, e, sg, of, rm);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    assert (acc) else begin bad++; $error("FAIL drive_accept got=0 expected=1"); end
  endtask

  // Single op with out_ready high: check latency and plan constants.
  task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                         input logic [25:0] sg, input logic of, input logic [2:0] rm,
                         input logic [31:0] x_res, input logic [4:0] x_fl);
    drive(s, e, sg, of, rm);
    lat = 1;
    while (!out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    total += 3;
    assert (lat == 2) else begin bad++; $error("FAIL %s_latency got=%0d expected=2", tag, lat); end
    assert (out_result === x_res) else begin
      bad++; $error("FAIL %s_result got=%h expected=%h", tag, out_result, x_res);
    end
    assert (out_fflags === x_fl) else begin
      bad++; $error("FAIL %s_fflags got=%h expected=%h", tag, out_fflags, x_fl);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) begin @(posedge clk); #1; end
    total++;
    assert (q.size() == 0) else begin bad++; $error("FAIL drain left=%0d expected=0", q.size()); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 8'd0, 26'd0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total += 4;
    assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b expected=0", out_valid); end
    assert (out_result === 32'd0) else begin bad++; $error("FAIL rst_result got=%h expected=0", out_result); end
    assert (out_fflags === 5'd0) else begin bad++; $error("FAIL rst_fflags got=%h expected=0", out_fflags); end
    assert (in_ready === 1'b1) else begin bad++; $error("FAIL rst_in_ready got=%b expected=1", in_ready); end
    @(posedge clk); #1;

    run_one("basic",   1'b0, 8'd127, 26'h2000003, 1'b0, 3'd0, 32'h3F800001, 5'h01);
    run_one("tie_even",1'b0, 8'd127, 26'h2000002, 1'b0, 3'd0, 32'h3F800000, 5'h01);
    run_one("tie_odd", 1'b0, 8'd127, 26'h2000006, 1'b0, 3'd0, 32'h3F800002, 5'h01);
    run_one("tie_rmm", 1'b0, 8'd127, 26'h2000002, 1'b0, 3'd4, 32'h3F800001, 5'h01);
    run_one("rm7_rne", 1'b0, 8'd127, 26'h2000006, 1'b0, 3'd7, 32'h3F800002, 5'h01);
    run_one("carry",   1'b0, 8'd127, 26'h3FFFFFE, 1'b0, 3'd0, 32'h40000000, 5'h01);
    run_one("carry_of",1'b0, 8'd254, 26'h3FFFFFE, 1'b0, 3'd0, 32'h7F800000, 5'h05);
    run_one("of_rtz",  1'b1, 8'd200, 26'h2000000, 1'b1, 3'd1, 32'hFF7FFFFF, 5'h05);
    run_one("of_rdn",  1'b1, 8'd200, 26'h2000000, 1'b1, 3'd2, 32'hFF800000, 5'h05);
    run_one("of_rup",  1'b1, 8'd200, 26'h2000000, 1'b1, 3'd3, 32'hFF7FFFFF, 5'h05);
    run_one("sub_rne", 1'b0, 8'd0,   26'h1FFFFFE, 1'b0, 3'd0, 32'h00800000, 5'h01);
    run_one("sub_rtz", 1'b0, 8'd0,   26'h1FFFFFE, 1'b0, 3'd1, 32'h007FFFFF, 5'h03);
    run_one("negzero", 1'b1, 8'd0,   26'h0000000, 1'b0, 3'd0, 32'h80000000, 5'h00);
    drain();

    // Backpressure: four back-to-back offers with the consumer stalled.
    bp_sig[0] = 26'h2000003; bp_sig[1] = 26'h2000006;
    bp_sig[2] = 26'h3FFFFFE; bp_sig[3] = 26'h2400001;
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 8'd127, bp_sig[idx], 1'b0, 3'd0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    total += 3;
    assert (idx == 2) else begin bad++; $error("FAIL bp_accepts got=%0d expected=2", idx); end
    assert (in_ready === 1'b0) else begin bad++; $error("FAIL bp_in_ready got=%b expected=0", in_ready); end
    assert (out_valid === 1'b1) else begin bad++; $error("FAIL bp_out_valid got=%b expected=1", out_valid); end
    held = out_result;
    @(posedge clk); #1;
    total++;
    assert (out_result === held) else begin bad++; $error("FAIL bp_hold got=%h expected=%h", out_result, held); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      set_in(1'b0, 8'd127, bp_sig[idx], 1'b0, 3'd0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    assert (idx == 4) else begin bad++; $error("FAIL bp_all_accepted got=%0d expected=4", idx); end
    drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    drive(1'b0, 8'd100, 26'h2000003, 1'b0, 3'd0);
    drive(1'b1, 8'd100, 26'h2000003, 1'b0, 3'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    total += 2;
    assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_mid_valid got=%b expected=0", out_valid); end
    assert (in_ready === 1'b1) else begin bad++; $error("FAIL rst_mid_ready got=%b expected=1", in_ready); end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_stale got=%b expected=0", out_valid); end
    run_one("post_rst", 1'b0, 8'd127, 26'h2000002, 1'b0, 3'd4, 32'h3F800001, 5'h01);

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      rnd = $urandom;
      in_sign = rnd[31];
      in_rm   = rnd[30:28];
      in_of   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0: in_exp = 8'd0;
        1: in_exp = 8'd254;
        default: in_exp = 8'($urandom_range(1, 253));
      endcase
      in_sig = rnd[25:0];
      in_sig[25] = (in_exp != 8'd0);
      in_uf = (in_exp == 8'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
